// File: rtl/mag_comp_serial.sv
// rtl/mag_comp_serial.sv - serial MSB-first magnitude comparator, signed/unsigned
module mag_comp_serial #(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [IW-1:0]    diff_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IW-1:0]    idx;
  logic             bit_a;
  logic             differ;
  logic             invert;

  // Current bit pair under inspection; the sign bit flips the sense in signed mode
  always_comb begin
    bit_a  = a_q[idx];
    differ = a_q[idx] ^ b_q[idx];
    invert = sm_q && (idx == TOP_IDX);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; abort masks done in the same cycle
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE) && !abort;
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (abort)                            state_nxt = IDLE;
        else if (differ || idx == '0)         state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, scan index and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      idx      <= '0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      diff_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sm_q     <= signed_mode;
            idx      <= TOP_IDX;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            diff_idx <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            diff_idx <= '0;
          end else if (differ) begin
            diff_idx <= idx;
            if (bit_a ^ invert) gt <= 1'b1;
            else                lt <= 1'b1;
          end else if (idx == '0) begin
            eq       <= 1'b1;
            diff_idx <= '0;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (abort) begin
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            diff_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_serial.sv
// tb/tb_mag_comp_serial.sv - scoreboard bench for mag_comp_serial
module tb_mag_comp_serial;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          signed_mode;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [IW-1:0] diff_idx;

  typedef struct {
    int gt;
    int eq;
    int lt;
    int idx;
    int lat;
    int e0;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  mag_comp_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .abort(abort), .a(a), .b(b), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt), .diff_idx(diff_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer comparison, highest set bit of a^b
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    logic [W-1:0] d;
    d = x ^ y;
    e.gt = s ? int'($signed(x) > $signed(y)) : int'(x > y);
    e.lt = s ? int'($signed(x) < $signed(y)) : int'(x < y);
    e.eq = int'(x == y);
    e.idx = 0;
    for (int i = 0; i < W; i++) if (d[i]) e.idx = i;
    e.lat = e.eq ? W : W - e.idx;
    e.e0  = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("gt", gt, e.gt);
        chk("eq", eq, e.eq);
        chk("lt", lt, e.lt);
        chk("diff_idx", diff_idx, e.idx);
        chk("latency", cyc - e.e0, e.lat);
      end
    end
  end

  // mode 0: normal (p>0 pulses a stray start at that cycle); 1: abort sampled at edge q; 2: reset in cycle q
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                         input int mode, input int q, input int p, input logic idle_abort);
    exp_t e;
    int   k;
    int   n;
    bit   stop;
    e = model(ta, tb_v, tsm);
    k = e.lat;
    a = ta; b = tb_v; signed_mode = tsm; start = 1'b1; abort = idle_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    e.e0 = cyc;
    chk("busy_accept", busy, 1);
    chk("flags_clear", {gt, eq, lt}, 0);
    chk("idx_clear", diff_idx, 0);
    if (mode == 0) sb.push_back(e);
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    n = 0;
    stop = 1'b0;
    while (busy && !stop && n < 60) begin
      @(negedge clk);
      n++;
      if (mode == 0 && p > 0) begin
        if (n == p) begin
          start = 1'b1; a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        end
        if (n == p + 1) start = 1'b0;
      end
      if (mode == 1) begin
        if (n == q)     abort = 1'b1;
        if (n == q + 1) abort = 1'b0;
      end
      if (mode == 2 && n == q) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {gt, eq, lt}, 0);
        chk("rst_idx", diff_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
      end
    end
    if (n >= 60) chk("busy_timeout", 1, 0);
    if (mode == 0) begin
      chk("busy_len", n, k + 2);
      chk("hold_gt", gt, e.gt);
      chk("hold_eq", eq, e.eq);
      chk("hold_lt", lt, e.lt);
      chk("hold_idx", diff_idx, e.idx);
      chk("done_seen", sb.size(), 0);
    end else if (mode == 1) begin
      chk("abort_idle", n, q + 1);
      chk("abort_flags", {gt, eq, lt}, 0);
      chk("abort_idx", diff_idx, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flags", {gt, eq, lt}, 0);
    chk("reset_idx", diff_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmp(8'h05, 8'h05, 1'b0, 0, 0, 2, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b0, 0, 0, 2, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b1, 0, 0, 0, 1'b0);
    run_cmp(8'hF3, 8'hF5, 1'b1, 0, 0, 7, 1'b1);
    run_cmp(8'h01, 8'h00, 1'b0, 1, 4, 0, 1'b0);
    run_cmp(8'h3C, 8'h3C, 1'b0, 2, 5, 0, 1'b0);
    run_cmp(8'h01, 8'h00, 1'b0, 0, 0, 0, 1'b0);
    for (int t = 0; t < 80; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      int           sel;
      int           k;
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      rs  = 1'($urandom);
      k   = model(ra, rb, rs).lat;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        run_cmp(ra, rb, rs, 0, 0, ($urandom_range(0, 1) == 1) ? $urandom_range(2, k + 1) : 0,
                1'($urandom));
      else if (sel < 9)
        run_cmp(ra, rb, rs, 1, $urandom_range(1, k + 1), 0, 1'b0);
      else
        run_cmp(ra, rb, rs, 2, $urandom_range(1, k + 1), 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mag_comp_serial.md
MAG_COMP_SERIAL -- requirements
Module: mag_comp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter IW, default $clog2(WIDTH), width of diff_idx.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to compare; sampled only in IDLE.
REQ-006 SHALL have port signed_mode, input, 1: 1 = two's-complement compare, 0 = unsigned; sampled with start.
REQ-007 SHALL have port abort, input, 1, synchronous cancel of an in-progress compare.
REQ-008 SHALL have port a, input, WIDTH, first operand; sampled with start.
REQ-009 SHALL have port b, input, WIDTH, second operand; sampled with start.
REQ-010 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-012 SHALL have port gt, output, 1, a > b.
REQ-013 SHALL have port eq, output, 1, a == b.
REQ-014 SHALL have port lt, output, 1, a < b.
REQ-015 SHALL have port diff_idx, output, IW, bit index of the most significant differing bit; 0 when equal.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-017 IDLE: start=1 at edge E0 SHALL latch a, b, signed_mode, set scan index to WIDTH-1, clear gt/eq/lt/diff_idx to 0, and enter SCAN.
REQ-018 SCAN: each edge SHALL compare one latched bit pair at the scan index, MSB first.
REQ-019 SCAN: on the first differing bit i, SHALL register diff_idx=i and set the flags; then SHALL enter DONE.
REQ-020 Unsigned flag rule: a[i]=1 SHALL give gt=1; otherwise lt=1.
REQ-021 Signed flag rule: when i=WIDTH-1 the sense SHALL be inverted (a[i]=1 gives lt=1); for any lower bit the unsigned rule SHALL apply.
REQ-022 SCAN: if bits are equal at index 0, SHALL set eq=1, diff_idx=0, and enter DONE; otherwise SHALL decrement the index and stay in SCAN.
REQ-023 Latency: with k = WIDTH-i for a mismatch (k = WIDTH if equal), flags SHALL update at edge Ek.
REQ-024 done SHALL be high for exactly the cycle following Ek, while the state is DONE.
REQ-025 DONE SHALL return to IDLE on the next edge.
REQ-026 gt/eq/lt/diff_idx SHALL hold their values after done until the next accepted start.
REQ-027 Exactly one of gt/eq/lt SHALL be high after done; all three SHALL be low between an accepted start and Ek.
REQ-028 start SHALL be ignored while busy=1, including in DONE; a start in the cycle after done SHALL be accepted.
REQ-029 abort=1 in SCAN or DONE SHALL force IDLE on the next edge, clear gt/eq/lt/diff_idx, and suppress done.
REQ-030 abort SHALL take priority over a coincident decision.
REQ-031 abort in IDLE SHALL have no effect, and a coincident start SHALL be accepted.
REQ-032 Changes on a, b, or signed_mode after E0 SHALL not affect the result in progress.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock, force IDLE and set busy, done, gt, eq, lt, and diff_idx to 0, including mid-SCAN.
REQ-034 After rst_n deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-035 unsigned a=8'h05, b=8'h05 -> eq=1, diff_idx=0, done in the cycle after E8, busy high for 9 cycles.
REQ-036 unsigned a=8'h80, b=8'h7F -> gt=1, diff_idx=7, done in the cycle after E1.
REQ-037 signed a=8'h80, b=8'h7F -> lt=1, diff_idx=7; signed a=8'hF3, b=8'hF5 -> lt=1, diff_idx=2, flags at E6.
REQ-038 start pulsed at E2 during a compare with new operands -> ignored, original result unchanged; back-to-back start accepted the cycle after done.
REQ-039 abort at E3 of a=8'h01, b=8'h00 -> no done, flags 0, busy low after E4; rst_n low at E4 of a new compare -> all outputs 0 immediately, a subsequent compare completes correctly.
